// File: rtl/sel_arbiter.sv
// Round-robin arbiter over 4 request lines: grants one channel at a time via a registered
// select index, releases on done or after MAX_HOLD cycles (pulsing timeout on forced release).
module sel_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] sel_nxt;
  logic       valid_nxt;
  logic       timeout_nxt;

  logic [1:0] pick_idx;
  logic       pick_ok;
  logic [1:0] scan_idx;
  logic       hold_hit;

  // Circular scan starting at ptr; the first set request bit wins.
  always_comb begin
    pick_idx = ptr;
    pick_ok  = 1'b0;
    scan_idx = ptr;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr + 2'(i);
      if (!pick_ok && req[scan_idx]) begin
        pick_idx = scan_idx;
        pick_ok  = 1'b1;
      end
    end
  end

  assign hold_hit = (cnt == HOLD_LAST);

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    valid_nxt   = sel_valid;
    timeout_nxt = 1'b0;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (pick_ok) begin
          sel_nxt   = pick_idx;
          valid_nxt = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (done || hold_hit) begin
          valid_nxt   = 1'b0;
          ptr_nxt     = sel + 2'd1;
          // A done that coincides with the hold limit counts as a normal release.
          timeout_nxt = hold_hit && !done;
          state_nxt   = RELEASE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      RELEASE: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      sel_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= 2'd0;
      cnt       <= 8'd0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      sel_valid <= valid_nxt;
      timeout   <= timeout_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sel_arbiter.sv
// Directed self-checking bench for sel_arbiter (MAX_HOLD = 8).
module tb_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic       sel_valid;
  logic       timeout;

  int total;
  int bad;

  sel_arbiter #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .sel_valid (sel_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b1;
    step();
    step();
    total++; if (sel !== 2'd0)       begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sel_valid); end
    total++; if (timeout !== 1'b0)   begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    rst  = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    step();
    total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b exp=0", sel_valid); end
  endtask

  task automatic test_basic_grant();
    do_reset();
    req = 4'b0010;
    step();
    total++; if (sel !== 2'd1)       begin bad++; $display("FAIL basic_sel got=%0d exp=1", sel); end
    total++; if (sel_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", sel_valid); end
    step();
    step();
    done = 1'b1;
    total++; if (sel_valid !== 1'b1) begin bad++; $display("FAIL basic_hold got=%b exp=1", sel_valid); end
    step();
    done = 1'b0;
    req  = 4'b0000;
    total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL basic_release got=%b exp=0", sel_valid); end
    total++; if (timeout !== 1'b0)   begin bad++; $display("FAIL basic_timeout got=%b exp=0", timeout); end
    total++; if (sel !== 2'd1)       begin bad++; $display("FAIL basic_sel_kept got=%0d exp=1", sel); end
    step();
    step();
    total++; if (sel_valid !== 1'b0 || timeout !== 1'b0)
      begin bad++; $display("FAIL basic_idle valid=%b timeout=%b exp=0/0", sel_valid, timeout); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_sel [5];
    exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2; exp_sel[3] = 2'd3; exp_sel[4] = 2'd0;
    do_reset();
    req = 4'b1111;
    step();
    total++; if (sel !== exp_sel[0] || sel_valid !== 1'b1)
      begin bad++; $display("FAIL rr_grant0 sel=%0d valid=%b exp=%0d/1", sel, sel_valid, exp_sel[0]); end
    for (int k = 1; k < 5; k++) begin
      done = 1'b1;
      step();
      done = 1'b0;
      total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL rr_release%0d got=%b exp=0", k, sel_valid); end
      step();
      total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL rr_gap%0d got=%b exp=0", k, sel_valid); end
      step();
      total++; if (sel !== exp_sel[k] || sel_valid !== 1'b1)
        begin bad++; $display("FAIL rr_grant%0d sel=%0d valid=%b exp=%0d/1", k, sel, sel_valid, exp_sel[k]); end
    end
    req = 4'b0000;
  endtask

  task automatic test_timeout_and_wrap();
    do_reset();
    req = 4'b0100;
    step();
    total++; if (sel !== 2'd2 || sel_valid !== 1'b1)
      begin bad++; $display("FAIL to_grant sel=%0d valid=%b exp=2/1", sel, sel_valid); end
    req = 4'b0000;
    for (int i = 1; i < 8; i++) begin
      step();
      total++; if (sel_valid !== 1'b1 || timeout !== 1'b0 || sel !== 2'd2)
        begin bad++; $display("FAIL to_hold%0d sel=%0d valid=%b timeout=%b exp=2/1/0", i, sel, sel_valid, timeout); end
    end
    step();
    total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL to_release_valid got=%b exp=0", sel_valid); end
    total++; if (timeout !== 1'b1)   begin bad++; $display("FAIL to_pulse got=%b exp=1", timeout); end
    req = 4'b1100;
    step();
    total++; if (timeout !== 1'b0 || sel_valid !== 1'b0)
      begin bad++; $display("FAIL to_pulse_end timeout=%b valid=%b exp=0/0", timeout, sel_valid); end
    step();
    total++; if (sel !== 2'd3 || sel_valid !== 1'b1)
      begin bad++; $display("FAIL to_ptr_next sel=%0d valid=%b exp=3/1", sel, sel_valid); end
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b1001;
    step();
    step();
    total++; if (sel !== 2'd0 || sel_valid !== 1'b1)
      begin bad++; $display("FAIL wrap_grant sel=%0d valid=%b exp=0/1", sel, sel_valid); end
    req = 4'b0000;
  endtask

  task automatic test_done_at_limit();
    do_reset();
    req = 4'b0001;
    step();
    for (int i = 1; i < 8; i++) step();
    done = 1'b1;
    total++; if (sel_valid !== 1'b1) begin bad++; $display("FAIL limit_still_valid got=%b exp=1", sel_valid); end
    step();
    done = 1'b0;
    req  = 4'b0000;
    total++; if (sel_valid !== 1'b0 || timeout !== 1'b0)
      begin bad++; $display("FAIL limit_done valid=%b timeout=%b exp=0/0", sel_valid, timeout); end
    step();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL limit_no_pulse got=%b exp=0", timeout); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    step();
    step();
    total++; if (sel !== 2'd2 || sel_valid !== 1'b1)
      begin bad++; $display("FAIL mid_grant sel=%0d valid=%b exp=2/1", sel, sel_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (sel_valid !== 1'b0 || sel !== 2'd0)
      begin bad++; $display("FAIL mid_async sel=%0d valid=%b exp=0/0", sel, sel_valid); end
    step();
    rst = 1'b0;
    req = 4'b1010;
    step();
    total++; if (sel !== 2'd1 || sel_valid !== 1'b1)
      begin bad++; $display("FAIL post_reset_grant sel=%0d valid=%b exp=1/1", sel, sel_valid); end
    req = 4'b0000;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_timeout_and_wrap();
    test_done_at_limit();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sel_arbiter.md
SEL_ARBITER -- requirements
Module: sel_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum number of cycles a grant is held before forced release; legal range is 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req  input  4  request lines; bit i requests channel i.
REQ-005 done  input  1  current grantee finished; sampled only in GRANT.
REQ-006 sel  output  2  registered index of granted channel; drives the downstream 2-to-4 decoder select.
REQ-007 sel_valid  output  1  registered; high while sel is a live grant.
REQ-008 timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-009 The block SHALL implement a three-state FSM: IDLE, GRANT, RELEASE.
REQ-010 The block SHALL keep a 2-bit priority pointer ptr and an 8-bit hold counter cnt.
REQ-011 In IDLE with req==0, the block SHALL stay in IDLE with sel_valid=0 and sel unchanged.
REQ-012 In IDLE with req!=0, the block SHALL select the first set bit found by scanning circularly from ptr (ptr, ptr+1, ... mod 4).
- At that same edge: load sel with the chosen index, set sel_valid=1, clear cnt, go to GRANT.
- Latency: req asserted before edge k gives sel_valid=1 after edge k.
REQ-013 In GRANT without a release condition, the block SHALL increment cnt by 1 per cycle and hold sel and sel_valid.
REQ-014 In GRANT, the block SHALL release when done=1 or cnt==MAX_HOLD-1; on release, at that edge:
- sel_valid=0
- ptr=sel+1 (mod 4; 3 wraps to 0)
- go to RELEASE.
REQ-015 The block SHALL pulse timeout=1 for exactly one cycle only when release is caused by cnt==MAX_HOLD-1 with done=0.
- If done=1 coincides with cnt==MAX_HOLD-1, the release SHALL be treated as a normal release: timeout=0.
REQ-016 RELEASE SHALL last exactly one cycle, then go to IDLE; sel keeps its last value and sel_valid stays 0.
REQ-017 Grants are non-preemptive: deasserting the granted req bit, or asserting other req bits, during GRANT SHALL NOT change sel or end the grant.
REQ-018 done in IDLE or RELEASE SHALL be ignored.
REQ-019 The minimum spacing between consecutive sel_valid rising edges SHALL be 3 cycles (GRANT ≥1, RELEASE 1, IDLE 1).
- Maximum grant length: MAX_HOLD cycles.
REQ-020 sel SHALL change only on the edge where sel_valid rises, so the decoder select is glitch-free during a grant.

Reset
REQ-021 While rst=1, regardless of clk, the block SHALL force: state=IDLE, sel=0, sel_valid=0, timeout=0, ptr=0, cnt=0.
REQ-022 Reset asserted mid-grant SHALL drop sel_valid immediately (asynchronously) and discard the grant.
- After rst falls, arbitration SHALL restart from ptr=0.
REQ-023 The first arbitration edge SHALL be the first rising clk edge after rst deasserts.

Verification
REQ-024 Reset then req=4'b0010, then done=1 three cycles after grant:
- sel=1 and sel_valid=1 one edge after req.
- sel_valid=0 on the done edge.
- Back in IDLE two edges later; timeout never 1.
REQ-025 Round-robin fairness: req=4'b1111 held; done pulsed each GRANT cycle:
- sel sequence 0,1,2,3,0.
- Consecutive grants spaced exactly 3 cycles.
REQ-026 Timeout with MAX_HOLD=8, req=4'b0100, done held 0:
- sel_valid high exactly 8 cycles.
- timeout=1 for one cycle on the release edge.
- ptr becomes 3 (next req=4'b1100 grants sel=3).
REQ-027 Pointer wrap: grant sel=3, then req=4'b1001 → next grant sel=0.
REQ-028 Simultaneous and corner events:
- done=1 on the cnt==7 cycle gives timeout=0.
- Dropping req during GRANT keeps the grant.
- rst pulse mid-grant gives sel_valid=0 immediately and sel=0.
- First grant after reset with req=4'b1010 is sel=1.
